// File: rtl/stream_packetizer_pkg.sv
// stream_packetizer_pkg: FSM states, header layout and default magic for the packetizer.
package stream_packetizer_pkg;
  typedef enum logic [1:0] {COLLECT, HEADER, PAYLOAD, TRAILER} pkt_state_t;
  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_SEQ_LSB = 8;
  localparam int HDR_COUNT_LSB = 0;
  localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hA5C3;
  function automatic logic [31:0] pkt_header(input logic [15:0] magic, input logic [7:0] seq, input logic [7:0] cnt);
    return (32'(magic) << HDR_MAGIC_LSB) | (32'(seq) << HDR_SEQ_LSB) | (32'(cnt) << HDR_COUNT_LSB);
  endfunction
endpackage

// File: rtl/stream_pkt_idle_timer.sv
// stream_pkt_idle_timer: saturating idle counter, expired while it sits at TIMEOUT-1.
module stream_pkt_idle_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] t;
  assign expired = t == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) t <= '0;
    else t <= clr ? '0 : (en && !expired) ? t + 1'b1 : t;
endmodule

// File: rtl/stream_packetizer.sv
// stream_packetizer: buffers input words and emits header, payload, XOR trailer packets.
module stream_packetizer
  import stream_packetizer_pkg::*;
#(
  parameter int INT_DATA_WIDTH = 32,
  parameter int INT_PAYLOAD_WORDS = 8,
  parameter int INT_TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] INT_HEADER_MAGIC = HDR_MAGIC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INT_DATA_WIDTH-1:0] i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic [INT_DATA_WIDTH-1:0] o_data,
  output logic                      o_valid,
  input  logic                      i_dready,
  output logic                      o_last,
  output logic [7:0]                o_seq
);
  localparam int DW = INT_DATA_WIDTH;
  localparam int CW = $clog2(INT_PAYLOAD_WORDS + 1);
  localparam int IW = INT_PAYLOAD_WORDS > 1 ? $clog2(INT_PAYLOAD_WORDS) : 1;
  pkt_state_t state;
  logic [CW-1:0] cnt, idx, cnt_nxt, idx_nxt;
  logic [7:0] seq;
  logic [DW-1:0] csum, csum_nxt, hdr;
  logic [DW-1:0] buffer [INT_PAYLOAD_WORDS];
  logic acc, expired, flush;
  assign o_seq = seq;
  assign acc = i_valid && o_ready;
  assign cnt_nxt = cnt + CW'(acc);
  assign idx_nxt = idx + 1'b1;
  assign csum_nxt = csum ^ o_data;
  assign hdr = DW'(pkt_header(INT_HEADER_MAGIC, seq, 8'(cnt_nxt)));
  // An accept always counts as activity, so it only flushes when it fills the buffer.
  assign flush = state == COLLECT && (acc ? cnt_nxt == CW'(INT_PAYLOAD_WORDS) : cnt != '0 && expired);
  stream_pkt_idle_timer #(.TIMEOUT(INT_TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state != COLLECT || acc),
    .en(cnt != '0),
    .expired(expired)
  );
  always_ff @(posedge clk)
    if (acc) buffer[cnt[IW-1:0]] <= i_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= COLLECT;
      cnt <= '0;
      idx <= '0;
      seq <= '0;
      csum <= '0;
      o_data <= '0;
      o_valid <= 1'b0;
      o_last <= 1'b0;
      o_ready <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          cnt <= cnt_nxt;
          o_ready <= !flush;
          if (flush) begin
            state <= HEADER;
            o_valid <= 1'b1;
            o_data <= hdr;
            csum <= hdr;
          end
        end
        HEADER: if (i_dready) begin
          state <= PAYLOAD;
          idx <= '0;
          o_data <= buffer[0];
        end
        PAYLOAD: if (i_dready) begin
          csum <= csum_nxt;
          idx <= idx_nxt;
          o_data <= idx_nxt == cnt ? csum_nxt : buffer[idx_nxt[IW-1:0]];
          o_last <= idx_nxt == cnt;
          if (idx_nxt == cnt) state <= TRAILER;
        end
        TRAILER: if (i_dready) begin
          state <= COLLECT;
          o_valid <= 1'b0;
          o_last <= 1'b0;
          o_ready <= 1'b1;
          cnt <= '0;
          seq <= seq + 1'b1;
        end
        default: state <= COLLECT;
      endcase
    end
endmodule

// File: tb/tb_stream_packetizer.sv
// tb_stream_packetizer: random and directed stimulus against a queue-based packet model.
module tb_stream_packetizer;
  localparam int PW = 4;
  localparam int TO = 16;
  typedef struct {logic [31:0] w; logic l;} ow_t;
  logic clk = 0, rst = 1, i_valid = 0, i_dready = 1;
  logic o_ready, o_valid, o_last;
  logic [31:0] i_data = 0, o_data;
  logic [7:0] o_seq;
  ow_t outq[$];
  logic [31:0] words[$];
  int idle, total, bad;
  logic [7:0] m_seq;
  logic m_ready;
  always #5 clk = ~clk;
  stream_packetizer #(.INT_DATA_WIDTH(32), .INT_PAYLOAD_WORDS(PW), .INT_TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .i_data(i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_data(o_data),
    .o_valid(o_valid),
    .i_dready(i_dready),
    .o_last(o_last),
    .o_seq(o_seq)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void mdl_reset();
    outq.delete();
    words.delete();
    idle = 0;
    m_seq = 0;
    m_ready = 0;
  endfunction
  // Advances the model across one rising edge with the given inputs.
  function automatic void mdl_edge(input logic iv, input logic [31:0] d, input logic id);
    logic [31:0] c;
    ow_t e;
    bit acc = iv && m_ready;
    bit fire = 0;
    if (outq.size() > 0 && id) begin
      e = outq.pop_front();
      if (e.l) m_seq++;
    end
    if (acc) begin
      words.push_back(d);
      idle = 0;
      fire = words.size() == PW;
    end else if (words.size() > 0) begin
      if (idle == TO - 1) fire = 1;
      else idle++;
    end
    if (fire) begin
      c = {16'hA5C3, m_seq, 8'(words.size())};
      outq.push_back('{c, 1'b0});
      foreach (words[i]) begin
        outq.push_back('{words[i], 1'b0});
        c ^= words[i];
      end
      outq.push_back('{c, 1'b1});
      words.delete();
      idle = 0;
    end
    m_ready = outq.size() == 0;
  endfunction
  task automatic step(input logic iv, input logic [31:0] d, input logic id);
    @(negedge clk);
    chk("ready", 32'(o_ready), 32'(m_ready));
    chk("valid", 32'(o_valid), 32'(outq.size() > 0));
    chk("seq", 32'(o_seq), 32'(m_seq));
    if (outq.size() > 0) begin
      chk("data", o_data, outq[0].w);
      chk("last", 32'(o_last), 32'(outq[0].l));
    end
    i_valid = iv;
    i_data = d;
    i_dready = id;
    mdl_edge(iv, d, id);
  endtask
  initial begin
    mdl_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_last", 32'(o_last), 0);
    chk("rst_data", o_data, 0);
    chk("rst_seq", 32'(o_seq), 0);
    rst = 0;
    mdl_edge(0, 0, 1);
    step(1, 32'h11, 1);
    step(1, 32'h22, 1);
    step(1, 32'h33, 1);
    step(1, 32'h44, 1);
    repeat (8) step(0, 0, 1);
    step(1, 32'hDEADBEEF, 1);
    repeat (24) step(0, 0, 1);
    repeat (3) begin
      step(1, $urandom, 1);
      repeat (14) step(0, 0, 1);
    end
    repeat (20) step(0, 0, 1);
    repeat (4) step(1, $urandom, 1);
    repeat (2) step(0, 0, 1);
    repeat (10) step(1, $urandom, 0);
    repeat (10) step(0, 0, 1);
    repeat (2816) step(1, $urandom, 1);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 99) < (i < 2000 ? 40 : 4), $urandom, $urandom_range(0, 3) != 0);
    repeat (40) step(0, 0, 1);
    repeat (4) step(1, $urandom, 1);
    repeat (2) step(0, 0, 1);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("abort_valid", 32'(o_valid), 0);
    chk("abort_ready", 32'(o_ready), 0);
    mdl_reset();
    @(negedge clk);
    chk("abort_seq", 32'(o_seq), 0);
    rst = 0;
    i_valid = 0;
    i_dready = 1;
    mdl_edge(0, 0, 1);
    repeat (4) step(1, $urandom, 1);
    repeat (10) step(0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
